// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave serving one burst at a time from a single-port 64-bit SRAM
module axi_sram_slave #(
  parameter logic [63:0] base  = 64'hc000_0000,
  parameter int          depth = 8192,
  parameter int          aw    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_axi_awid,
  input  logic [63:0]   s_axi_awaddr,
  input  logic [7:0]    s_axi_awlen,
  input  logic [2:0]    s_axi_awsize,
  input  logic [1:0]    s_axi_awburst,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [63:0]   s_axi_wdata,
  input  logic [7:0]    s_axi_wstrb,
  input  logic          s_axi_wlast,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [7:0]    s_axi_bid,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [7:0]    s_axi_arid,
  input  logic [63:0]   s_axi_araddr,
  input  logic [7:0]    s_axi_arlen,
  input  logic [2:0]    s_axi_arsize,
  input  logic [1:0]    s_axi_arburst,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [7:0]    s_axi_rid,
  output logic [63:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rlast,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic          mem_en,
  output logic [7:0]    mem_we,
  output logic [aw-1:0] mem_addr,
  output logic [63:0]   mem_wdat,
  input  logic [63:0]   mem_rdat
);

  localparam logic [63:0] span = 64'(depth) << 3;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RRESP} state_t;

  state_t      r_state;
  logic        r_prio;            // 0: write wins a tie, 1: read wins
  logic [7:0]  r_id;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_bvalid;
  logic [7:0]  r_bid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [7:0]  r_rid;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic        r_rgate;

  logic [63:0] w_off;
  logic        w_oor;
  logic        w_gate;
  logic [63:0] w_step;
  logic [63:0] w_wmask;
  logic [63:0] w_inc;
  logic [63:0] w_next;
  logic        w_both;
  logic        w_aw_grant;
  logic        w_ar_grant;
  logic        w_last_beat;
  logic        w_wbeat;

  // Offset wraps below base, so one unsigned compare covers both window edges.
  assign w_off       = r_addr - base;
  assign w_oor       = (w_off >= span);
  assign w_gate      = r_err | w_oor;
  assign w_step      = 64'd1 << r_size;
  assign w_wmask     = ((64'(r_len) + 64'd1) << r_size) - 64'd1;
  assign w_inc       = r_addr + w_step;
  assign w_both      = s_axi_awvalid & s_axi_arvalid;
  assign w_aw_grant  = (r_state == IDLE) & s_axi_awvalid & (~s_axi_arvalid | ~r_prio);
  assign w_ar_grant  = (r_state == IDLE) & s_axi_arvalid & (~s_axi_awvalid | r_prio);
  assign w_last_beat = (r_cnt == r_len);
  assign w_wbeat     = (r_state == WDATA) & s_axi_wvalid;

  always_comb begin
    w_next = r_addr;
    case (r_burst)
      2'd1:    w_next = w_inc;
      2'd2:    w_next = (r_addr & ~w_wmask) | (w_inc & w_wmask);
      default: w_next = r_addr;
    endcase
  end

  assign s_axi_awready = w_aw_grant;
  assign s_axi_arready = w_ar_grant;
  assign s_axi_wready  = (r_state == WDATA);
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  // SRAM holds its output until the next access, so rdata is stable under backpressure.
  assign s_axi_rdata   = (r_rvalid & ~r_rgate) ? mem_rdat : 64'd0;

  assign mem_addr = w_off[aw+2:3];
  assign mem_wdat = s_axi_wdata;

  always_comb begin
    mem_en = 1'b0;
    mem_we = 8'd0;
    if (w_wbeat & ~w_gate) begin
      mem_en = 1'b1;
      mem_we = s_axi_wstrb;
    end else if ((r_state == RREQ) & ~w_gate) begin
      mem_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_id     <= 8'd0;
      r_addr   <= 64'd0;
      r_len    <= 8'd0;
      r_size   <= 3'd0;
      r_burst  <= 2'd0;
      r_cnt    <= 8'd0;
      r_err    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid    <= 8'd0;
      r_bresp  <= 2'd0;
      r_rvalid <= 1'b0;
      r_rid    <= 8'd0;
      r_rresp  <= 2'd0;
      r_rlast  <= 1'b0;
      r_rgate  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((w_aw_grant | w_ar_grant) & w_both) r_prio <= ~r_prio;
          if (w_aw_grant) begin
            r_id    <= s_axi_awid;
            r_addr  <= s_axi_awaddr;
            r_len   <= s_axi_awlen;
            r_size  <= s_axi_awsize;
            r_burst <= s_axi_awburst;
            r_cnt   <= 8'd0;
            r_err   <= (s_axi_awburst == 2'd3);
            r_state <= WDATA;
          end else if (w_ar_grant) begin
            r_id    <= s_axi_arid;
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= s_axi_arsize;
            r_burst <= s_axi_arburst;
            r_cnt   <= 8'd0;
            r_err   <= (s_axi_arburst == 2'd3);
            r_state <= RREQ;
          end
        end
        WDATA: begin
          if (s_axi_wvalid) begin
            if (s_axi_wlast | w_last_beat) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (w_gate | (s_axi_wlast ^ w_last_beat)) ? 2'b10 : 2'b00;
              r_state  <= WRESP;
            end else begin
              r_err  <= w_gate;
              r_addr <= w_next;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        WRESP: begin
          if (s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RREQ: begin
          r_err    <= w_gate;
          r_rgate  <= w_gate;
          r_rvalid <= 1'b1;
          r_rid    <= r_id;
          r_rresp  <= w_gate ? 2'b10 : 2'b00;
          r_rlast  <= w_last_beat;
          r_state  <= RRESP;
        end
        RRESP: begin
          if (s_axi_rready) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_state <= IDLE;
            end else begin
              r_addr  <= w_next;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= RREQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized bench for axi_sram_slave against a byte-level memory model
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam logic [63:0] BASE  = 64'hc000_0000;
  localparam int          DEPTH = 8192;
  localparam logic [63:0] TOP   = BASE + 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_axi_awid = '0, s_axi_awlen = '0, s_axi_arid = '0, s_axi_arlen = '0;
  logic [63:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0;
  logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
  logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 0, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic        s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast;
  logic [7:0]  s_axi_bid, s_axi_rid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [63:0] s_axi_rdata;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdat;
  logic [63:0] mem_rdat = '0;

  always #5 clk = ~clk;

  axi_sram_slave #(.base(BASE), .depth(DEPTH), .aw(13)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  // Physical SRAM attached to the DUT
  logic [63:0] sram [0:DEPTH-1];
  logic [63:0] nw;
  initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 8'd0) mem_rdat <= sram[mem_addr];
      else begin
        nw = sram[mem_addr];
        for (int b = 0; b < 8; b++) if (mem_we[b]) nw[8*b +: 8] = mem_wdat[8*b +: 8];
        sram[mem_addr] <= nw;
      end
    end
  end

  int          n_mem_en = 0;
  logic [12:0] mem_log [$];
  always @(posedge clk) if (mem_en) begin
    n_mem_en++;
    mem_log.push_back(mem_addr);
  end

  int n_vec = 0, n_bad = 0;
  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected memory contents per word index
  logic [63:0] ref_mem [int];
  logic [7:0]  t_id, t_len;
  logic [63:0] t_addr;
  logic [2:0]  t_size;
  logic [1:0]  t_burst;
  int          t_last_at;
  logic [63:0] t_data [16];
  logic [7:0]  t_strb [16];

  function automatic logic [63:0] ref_rd(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 64'd0;
  endfunction

  function automatic logic [63:0] beat_addr(input int i);
    longint unsigned step, win, lo;
    step = 64'd1 << t_size;
    win  = (64'(t_len) + 1) * step;
    case (t_burst)
      2'd1: return t_addr + 64'(i) * step;
      2'd2: begin
        lo = (t_addr / win) * win;
        return lo + ((t_addr - lo + 64'(i) * step) % win);
      end
      default: return t_addr;
    endcase
  endfunction

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3) & (DEPTH - 1);
  endfunction

  task automatic send_aw(input bit keep);
    int k;
    s_axi_awid = t_id; s_axi_awaddr = t_addr; s_axi_awlen = t_len;
    s_axi_awsize = t_size; s_axi_awburst = t_burst; s_axi_awvalid = 1'b1;
    k = 0; #1;
    while (!s_axi_awready && k < 50) begin @(negedge clk); #1; k++; end
    expect_eq("aw_handshake", s_axi_awready, 1);
    @(posedge clk); @(negedge clk);
    if (!keep) s_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input bit keep);
    int k;
    s_axi_arid = t_id; s_axi_araddr = t_addr; s_axi_arlen = t_len;
    s_axi_arsize = t_size; s_axi_arburst = t_burst; s_axi_arvalid = 1'b1;
    mem_log.delete();
    k = 0; #1;
    while (!s_axi_arready && k < 50) begin @(negedge clk); #1; k++; end
    expect_eq("ar_handshake", s_axi_arready, 1);
    @(posedge clk); @(negedge clk);
    if (!keep) s_axi_arvalid = 1'b0;
  endtask

  task automatic w_phase();
    int nb, k, w;
    bit err;
    logic [63:0] a, word;
    nb  = (t_last_at < int'(t_len)) ? t_last_at + 1 : int'(t_len) + 1;
    err = (t_burst == 2'd3);
    for (int i = 0; i < nb; i++) begin
      a = beat_addr(i);
      err |= !in_range(a);
      if (!err) begin
        w = widx(a);
        word = ref_rd(w);
        for (int b = 0; b < 8; b++) if (t_strb[i][b]) word[8*b +: 8] = t_data[i][8*b +: 8];
        ref_mem[w] = word;
      end
      s_axi_wdata = t_data[i]; s_axi_wstrb = t_strb[i];
      s_axi_wlast = (i == nb - 1); s_axi_wvalid = 1'b1;
      k = 0; #1;
      while (!s_axi_wready && k < 50) begin @(negedge clk); #1; k++; end
      expect_eq("w_ready", s_axi_wready, 1);
      @(posedge clk); @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    k = 0; #1;
    while (!s_axi_bvalid && k < 50) begin @(negedge clk); #1; k++; end
    expect_eq("bvalid", s_axi_bvalid, 1);
    expect_eq("bid", s_axi_bid, t_id);
    expect_eq("bresp", s_axi_bresp, (err || nb != int'(t_len) + 1) ? 64'd2 : 64'd0);
    @(posedge clk); @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // stall < 0 picks a random 0..2 cycle rready hold-off per beat
  task automatic r_phase(input bit chk_lat, input int stall);
    int k, s;
    bit err;
    logic [63:0] a, exp_d;
    logic [12:0] exp_q [$];
    err = (t_burst == 2'd3);
    for (int i = 0; i <= int'(t_len); i++) begin
      a = beat_addr(i);
      err |= !in_range(a);
      exp_d = err ? 64'd0 : ref_rd(widx(a));
      if (!err) exp_q.push_back(13'(widx(a)));
      k = 1; #1;
      while (!s_axi_rvalid && k < 20) begin @(negedge clk); #1; k++; end
      expect_eq("rvalid", s_axi_rvalid, 1);
      if (chk_lat && i == 0) expect_eq("rd_latency", k, 2);
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      repeat (s) begin
        expect_eq("stall_rdata", s_axi_rdata, exp_d);
        expect_eq("stall_rid", s_axi_rid, t_id);
        expect_eq("stall_rlast", s_axi_rlast, i == int'(t_len));
        @(negedge clk); #1;
      end
      expect_eq("rid", s_axi_rid, t_id);
      expect_eq("rdata", s_axi_rdata, exp_d);
      expect_eq("rresp", s_axi_rresp, err ? 64'd2 : 64'd0);
      expect_eq("rlast", s_axi_rlast, i == int'(t_len));
      s_axi_rready = 1'b1;
      @(posedge clk); @(negedge clk);
      s_axi_rready = 1'b0;
    end
    expect_eq("rd_mem_count", mem_log.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < mem_log.size(); j++)
      expect_eq("rd_mem_addr", mem_log[j], exp_q[j]);
  endtask

  task automatic set_txn(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    t_id = id; t_addr = addr; t_len = len; t_size = 3'd3; t_burst = burst; t_last_at = int'(len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [12:0] wrap_exp [4];
    int base_en, k;
    wrap_exp = '{13'h22, 13'h23, 13'h20, 13'h21};

    repeat (3) @(negedge clk);
    expect_eq("rst_awready", s_axi_awready, 0);
    expect_eq("rst_arready", s_axi_arready, 0);
    expect_eq("rst_wready", s_axi_wready, 0);
    expect_eq("rst_bvalid", s_axi_bvalid, 0);
    expect_eq("rst_rvalid", s_axi_rvalid, 0);
    expect_eq("rst_ids", {s_axi_bid, s_axi_rid}, 0);
    expect_eq("rst_resp", {s_axi_bresp, s_axi_rresp, s_axi_rlast}, 0);
    expect_eq("rst_mem", {mem_en, mem_we}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single write then read
    set_txn(8'h5a, BASE + 64'h10, 8'd0, 2'd1);
    t_data[0] = 64'h1122334455667788; t_strb[0] = 8'hff;
    send_aw(0); w_phase();
    t_id = 8'h33;
    send_ar(0); r_phase(1, 0);

    // INCR write then WRAP read
    set_txn(8'h01, BASE + 64'h100, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin t_data[i] = 64'(i); t_strb[i] = 8'hff; end
    send_aw(0); w_phase();
    set_txn(8'h02, BASE + 64'h110, 8'd3, 2'd2);
    send_ar(0); r_phase(0, 0);
    for (int j = 0; j < 4; j++) expect_eq("wrap_mem_addr", mem_log[j], wrap_exp[j]);

    // partial strobe
    set_txn(8'h03, BASE + 64'h200, 8'd0, 2'd1);
    t_data[0] = 64'd0; t_strb[0] = 8'hff;
    send_aw(0); w_phase();
    t_data[0] = 64'hffffffffffffffff; t_strb[0] = 8'h0f;
    send_aw(0); w_phase();
    send_ar(0); r_phase(0, 0);

    // arbitration with both valids held
    set_txn(8'h40, BASE + 64'h400, 8'd0, 2'd1);
    s_axi_arid = t_id; s_axi_araddr = t_addr; s_axi_arlen = t_len;
    s_axi_arsize = t_size; s_axi_arburst = t_burst; s_axi_arvalid = 1'b1;
    s_axi_awid = t_id; s_axi_awaddr = t_addr; s_axi_awlen = t_len;
    s_axi_awsize = t_size; s_axi_awburst = t_burst; s_axi_awvalid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      t_id = 8'h40 + 8'(g); t_data[0] = 64'h1000 + 64'(g); t_strb[0] = 8'hff;
      s_axi_awid = t_id; s_axi_arid = t_id;
      mem_log.delete();
      #1;
      expect_eq("grant_aw", s_axi_awready, g != 1);
      expect_eq("grant_ar", s_axi_arready, g == 1);
      @(posedge clk); @(negedge clk);
      if (g != 1) w_phase(); else r_phase(0, 0);
    end
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;

    // write just past the window
    set_txn(8'h50, TOP, 8'd0, 2'd1);
    t_data[0] = 64'hdead; t_strb[0] = 8'hff;
    base_en = n_mem_en;
    send_aw(0); w_phase();
    expect_eq("oor_mem_en", n_mem_en - base_en, 0);

    // illegal burst read
    set_txn(8'h51, BASE + 64'h10, 8'd1, 2'd3);
    send_ar(0); r_phase(0, 0);

    // early wlast
    set_txn(8'h52, BASE + 64'h300, 8'd3, 2'd1);
    t_last_at = 1;
    for (int i = 0; i < 4; i++) begin t_data[i] = 64'h77 + 64'(i); t_strb[i] = 8'hff; end
    send_aw(0); w_phase();

    // read backpressure
    set_txn(8'h53, BASE + 64'h10, 8'd0, 2'd1);
    send_ar(0); r_phase(0, 5);

    // reset mid-read
    set_txn(8'h54, BASE + 64'h100, 8'd1, 2'd1);
    send_ar(0);
    k = 0; #1;
    while (!s_axi_rvalid && k < 20) begin @(negedge clk); #1; k++; end
    expect_eq("pre_rst_rvalid", s_axi_rvalid, 1);
    rst = 1'b0; #1;
    expect_eq("mid_rst_rvalid", s_axi_rvalid, 0);
    expect_eq("mid_rst_mem_en", mem_en, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      expect_eq("post_rst_quiet", {s_axi_rvalid, s_axi_bvalid}, 0);
    end
    set_txn(8'h55, BASE + 64'h108, 8'd0, 2'd1);
    send_ar(0); r_phase(1, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [63:0] off;
      t_id = 8'($urandom); t_size = 3'($urandom_range(0, 3));
      t_burst = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (t_burst == 2'd2) t_len = 8'((1 << $urandom_range(1, 3)) - 1);
      else t_len = 8'($urandom_range(0, 7));
      t_last_at = int'(t_len);
      off = 64'($urandom_range(0, 'h7ff)) & ~((64'd1 << t_size) - 64'd1);
      if ($urandom_range(0, 7) == 0) t_addr = TOP - 64'($urandom_range(1, 4)) * 64'd8;
      else t_addr = BASE + 64'h1000 + off;
      for (int i = 0; i < 16; i++) begin
        t_data[i] = {$urandom, $urandom}; t_strb[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin send_aw(0); w_phase(); end
      else begin send_ar(0); r_phase(0, -1); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave endpoint consuming the core's 64-bit AXI master port (m_axi_*) and serving it from a single-port synchronous SRAM (boot/scratch memory).
- One transaction in flight; INCR/FIXED/WRAP bursts; out-of-range or malformed requests complete with SLVERR and no memory side effects.
- Sits directly downstream of the core's AXI master, either behind the SoC interconnect or wired point-to-point in single-core builds.

Parameters:
base, 64'hc0000000, byte base address of the SRAM window
depth, 8192, number of 64-bit words; power of two
aw, 13, word index width, equal to log2(depth)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
s_axi_aw{id,addr,len,size,burst}  in  8,64,8,3,2  write address channel payload
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata, s_axi_wstrb, s_axi_wlast  in  64,8,1  write data channel
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid, s_axi_bresp  out  8,2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_ar{id,addr,len,size,burst}  in  8,64,8,3,2  read address channel payload
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast  out  8,64,2,1  read data channel
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
mem_en  out  1  SRAM access enable
mem_we  out  8  byte write enables; 0 means read
mem_addr  out  aw  word index
mem_wdat  out  64  write data
mem_rdat  in  64  read data; valid the cycle after a read mem_en and held until the next mem_en

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, priority bit = write.
- Reset values: all ready/valid outputs 0; bid, rid, bresp, rresp, rlast 0; mem_en 0, mem_we 0; beat counter 0.
- A reset mid-burst abandons the burst. No response is issued afterwards.
- States: IDLE, WDATA, WRESP, RREQ, RRESP.
- IDLE, arbitration:
  - awready = awvalid & (!arvalid | prio==write).
  - arready = arvalid & (!awvalid | prio==read).
  - Both valid: grant goes to prio, and prio toggles on each grant made while both were valid.
  - On a handshake: latch id, addr, len, size, burst; clear the beat counter; go to WDATA or RREQ.
- Address step per beat:
  - Step = 1<<size.
  - FIXED (0): address held constant.
  - INCR (1): addr += step.
  - WRAP (2): addr wraps inside the aligned (len+1)*step window.
  - burst==3 is illegal: whole transaction flagged error.
- Error flag (sticky per transaction): set by illegal burst, or by any beat whose address falls outside [base, base+depth*8).
- Memory gating: a beat with the error flag set, or whose own address is out of range, drives mem_en=0 and returns rdata 0.
- mem_addr = (addr-base)>>3, truncated to aw bits.
- WDATA:
  - wready=1.
  - Each W handshake drives, combinationally in the same cycle: mem_en=1, mem_we=wstrb, mem_wdat=wdata.
  - Go to WRESP when wlast=1 or the counter equals len.
  - If wlast and counter==len disagree, the error flag is set.
  - No data is accepted beyond beat len.
- WRESP: bvalid=1, bid=latched id, bresp = error ? 2'b10 : 2'b00. On bready go to IDLE.
- RREQ: mem_en=1, mem_we=0 for exactly one cycle; next state RRESP.
- RRESP:
  - rvalid=1; rdata = mem_rdat (0 if the beat is gated); rresp per beat error; rlast = (counter==len); rid = latched id.
  - Outputs are held stable while rready=0.
  - On handshake: if rlast go to IDLE, else advance the address and counter and go to RREQ.
- Throughput and latency:
  - Reads: 2 cycles/beat minimum; first rvalid 2 cycles after the AR handshake.
  - Writes: 1 beat/cycle.
- AXI rule: ready never depends on a different channel's ready.

Test Plan:
- Single write then read: AW addr=c0000010 len=0 size=3, W data=1122334455667788 strb=ff, then AR same address -> bresp=0 with bid echoed; 2 cycles after the AR handshake rvalid=1, rdata=1122334455667788, rlast=1.
- INCR len=3 write of data 0..3 at c0000100, then WRAP len=3 read at c0000110 -> mem_addr sequence 0x22,0x23,0x20,0x21; rdata sequence 2,3,0,1.
- Partial strobe: write strb=0f data=ffffffffffffffff over a word holding 0 -> readback 00000000ffffffff.
- Simultaneous awvalid and arvalid held for three transactions -> grant order write, read, write.
- Error paths:
  - addr=base+depth*8 write -> bresp=2, mem_en never high.
  - burst=3 read len=1 -> two beats, each rresp=2, rdata=0.
  - Early wlast on beat 1 of a len=3 burst -> bresp=2.
- Backpressure and reset:
  - rready=0 for 5 cycles -> rdata/rid/rlast stable.
  - rst pulled low mid-read -> rvalid=0 immediately; IDLE after release.
